// File: rtl/reg8x16_writer.sv
// Write side of the 8x16 register bank: 1-entry hold buffer on a valid/ready handshake,
// byte-enabled commit, freeze stall, clr_all, pending scoreboard. Option macro: ZERO_REG_EN.
module reg8x16_writer #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [1:0]       wr_be,
  input  logic             freeze,
  input  logic             clr_all,
  output logic [WIDTH-1:0] A0,
  output logic [WIDTH-1:0] A1,
  output logic [WIDTH-1:0] A2,
  output logic [WIDTH-1:0] A3,
  output logic [WIDTH-1:0] A4,
  output logic [WIDTH-1:0] A5,
  output logic [WIDTH-1:0] A6,
  output logic [WIDTH-1:0] A7,
  output logic [7:0]       pend,
  output logic             commit_strobe
);

  logic [WIDTH-1:0] regs_r [8];
  logic             hold_valid_r;
  logic [2:0]       hold_addr_r;
  logic [WIDTH-1:0] hold_data_r;
  logic [1:0]       hold_be_r;
  logic [7:0]       pend_r;
  logic             commit_strobe_r;

  logic             accept_s;
  logic             commit_s;
  logic             wr_en_s;
  logic             hold_valid_s;
  logic [2:0]       hold_addr_s;
  logic [WIDTH-1:0] hold_data_s;
  logic [1:0]       hold_be_s;
  logic [7:0]       pend_s;
  logic [WIDTH-1:0] merged_s;

  // Lanes with a clear enable keep the old byte; WIDTH is fixed at two bytes.
  function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_v,
                                                   input logic [WIDTH-1:0] new_v,
                                                   input logic [1:0]       be);
    logic [WIDTH-1:0] res;
    res[15:8] = be[1] ? new_v[15:8] : old_v[15:8];
    res[7:0]  = be[0] ? new_v[7:0]  : old_v[7:0];
    return res;
  endfunction

  assign wr_ready = !clr_all && (!hold_valid_r || !freeze);

  // Handshake, commit decision and next hold-buffer state.
  always_comb begin
    accept_s     = wr_valid && wr_ready;
    commit_s     = hold_valid_r && !freeze && !clr_all;
    hold_valid_s = hold_valid_r;
    hold_addr_s  = hold_addr_r;
    hold_data_s  = hold_data_r;
    hold_be_s    = hold_be_r;
    if (clr_all) begin
      hold_valid_s = 1'b0;
    end else if (accept_s) begin
      hold_valid_s = 1'b1;
      hold_addr_s  = wr_addr;
      hold_data_s  = wr_data;
      hold_be_s    = wr_be;
    end else if (commit_s) begin
      hold_valid_s = 1'b0;
    end else begin
      hold_valid_s = hold_valid_r;
    end
    if (hold_valid_s) begin
      pend_s = 8'h01 << hold_addr_s;
    end else begin
      pend_s = 8'h00;
    end
`ifdef ZERO_REG_EN
    wr_en_s = commit_s && (hold_addr_r != 3'd0);
`else
    wr_en_s = commit_s;
`endif
    merged_s = merge_bytes(regs_r[hold_addr_r], hold_data_r, hold_be_r);
  end

  // Register bank, hold buffer, scoreboard and strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs_r[i] <= RST_VAL;
      hold_valid_r    <= 1'b0;
      hold_addr_r     <= 3'd0;
      hold_data_r     <= {WIDTH{1'b0}};
      hold_be_r       <= 2'b00;
      pend_r          <= 8'h00;
      commit_strobe_r <= 1'b0;
    end else begin
      if (clr_all) begin
        for (int i = 0; i < 8; i++) regs_r[i] <= RST_VAL;
      end else if (wr_en_s) begin
        regs_r[hold_addr_r] <= merged_s;
      end
      hold_valid_r    <= hold_valid_s;
      hold_addr_r     <= hold_addr_s;
      hold_data_r     <= hold_data_s;
      hold_be_r       <= hold_be_s;
      pend_r          <= pend_s;
      commit_strobe_r <= commit_s;
    end
  end

`ifdef ZERO_REG_EN
  assign A0 = {WIDTH{1'b0}};
`else
  assign A0 = regs_r[0];
`endif
  assign A1            = regs_r[1];
  assign A2            = regs_r[2];
  assign A3            = regs_r[3];
  assign A4            = regs_r[4];
  assign A5            = regs_r[5];
  assign A6            = regs_r[6];
  assign A7            = regs_r[7];
  assign pend          = pend_r;
  assign commit_strobe = commit_strobe_r;

endmodule
